// File: rtl/cache_pkg.sv
// Shared cache types: the 32-bit word and the instruction-cache fill FSM states.
package cache_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hits, multi-word block fill on miss.
// Frames hold valid, tag and BLKWORDS data words; inval clears every valid bit.
module icache_dm #(
    parameter int unsigned SETS     = 16,
    parameter int unsigned BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        inval,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    import cache_pkg::*;

    localparam int unsigned OFFW = $clog2(BLKWORDS);
    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 32 - IDXW - OFFW - 2;
    localparam int unsigned CNTW = (OFFW > 0) ? OFFW : 1;

    if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("icache_dm: SETS must be a power of two >= 2");
    end
    if (BLKWORDS < 1 || (BLKWORDS & (BLKWORDS - 1)) != 0) begin : g_bad_blkwords
        $error("icache_dm: BLKWORDS must be a power of two >= 1");
    end

    icache_state_t   state;
    logic [CNTW-1:0] cnt;
    word_t           fill_base;

    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags [SETS];
    word_t           data [SETS][BLKWORDS];

    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic [CNTW-1:0] req_off;
    word_t           req_base;
    logic [IDXW-1:0] fill_idx;
    logic [TAGW-1:0] fill_tag;
    logic            tag_hit;
    logic            last_word;

    // Field extraction by shifting keeps BLKWORDS=1 (empty offset field) legal.
    assign req_idx  = IDXW'(imemaddr >> (OFFW + 2));
    assign req_tag  = TAGW'(imemaddr >> (IDXW + OFFW + 2));
    assign req_off  = CNTW'(imemaddr >> 2) & CNTW'(BLKWORDS - 1);
    assign req_base = imemaddr & ~word_t'(BLKWORDS * 4 - 1);
    assign fill_idx = IDXW'(fill_base >> (OFFW + 2));
    assign fill_tag = TAGW'(fill_base >> (IDXW + OFFW + 2));

    assign tag_hit   = valid[req_idx] && (tags[req_idx] == req_tag);
    assign last_word = (cnt == CNTW'(BLKWORDS - 1));

    assign ihit     = (state == IDLE) && imemREN && !inval && tag_hit;
    assign imemload = data[req_idx][req_off];
    assign iREN     = (state == FETCH);
    assign iaddr    = fill_base + (word_t'(cnt) << 2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_base <= '0;
            valid     <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                tags[IDXW'(s)] <= '0;
                for (int unsigned w = 0; w < BLKWORDS; w++) begin
                    data[IDXW'(s)][CNTW'(w)] <= '0;
                end
            end
        end else if (inval) begin
            // Invalidate outranks any fill in progress, including its final word.
            valid <= '0;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !tag_hit) begin
                        fill_base <= req_base;
                        cnt       <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        data[fill_idx][cnt] <= iload;
                        if (last_word) begin
                            tags[fill_idx]  <= fill_tag;
                            valid[fill_idx] <= 1'b1;
                            cnt             <= '0;
                            state           <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm (SETS=16, BLKWORDS=2): memory word requests and
// hit responses are queued by the stimulus and consumed by an independent monitor.
module tb_icache_dm;

    typedef struct {
        logic [31:0]  data;
        int unsigned  cyc;
    } hit_exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        inval = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload = '0;

    int unsigned cyc = 0;
    int unsigned waitn = 0;
    int unsigned wcnt = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] addr_q [$];
    hit_exp_t    hit_q [$];

    icache_dm #(.SETS(16), .BLKWORDS(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .inval    (inval),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory: inserts waitn busy cycles before every word; data is 0xAAAA0000 + (addr - 0x40).
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (iREN) begin
                if (wcnt < waitn) begin
                    iwait = 1'b1;
                    wcnt  = wcnt + 1;
                end else begin
                    iwait = 1'b0;
                    wcnt  = 0;
                end
            end else begin
                iwait = 1'b0;
                wcnt  = 0;
            end
            iload = 32'hAAAA0000 + iaddr - 32'h40;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT accepts a word or signals a hit.
    initial begin
        hit_exp_t h;
        logic [31:0] a;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (iREN && iwait && addr_q.size() > 0) begin
                    check("iaddr_held", iaddr, addr_q[0]);
                end
                if (iREN && !iwait) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_fetch", iaddr, 32'hFFFFFFFF);
                    end else begin
                        a = addr_q.pop_front();
                        check("fetch_addr", iaddr, a);
                    end
                end
                if (ihit) begin
                    if (hit_q.size() == 0) begin
                        check("unexpected_hit", imemaddr, 32'hFFFFFFFF);
                    end else begin
                        h = hit_q.pop_front();
                        check("hit_data", imemload, h.data);
                        check("hit_cycle", cyc, h.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, output int unsigned t0);
        @(posedge CLK);
        #1;
        imemaddr = a;
        imemREN  = 1'b1;
        t0       = cyc;
    endtask

    task automatic expect_fill(input logic [31:0] base);
        addr_q.push_back(base);
        addr_q.push_back(base + 32'h4);
    endtask

    task automatic expect_hit(input logic [31:0] d, input int unsigned c);
        hit_exp_t h;
        h.data = d;
        h.cyc  = c;
        hit_q.push_back(h);
    endtask

    task automatic wait_hit(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (ihit) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic req(input string name, input logic [31:0] a, input logic [31:0] d,
                       input bit miss, input int unsigned lat);
        int unsigned t0;
        issue(a, t0);
        if (miss) expect_fill(a);
        expect_hit(d, t0 + lat);
        wait_hit(name);
    endtask

    initial begin
        int unsigned t0;

        // Reset state, with a fetch already requested
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        check("rst_iREN", {31'b0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        imemREN = 1'b0;
        RST     = 1'b0;

        // Cold miss, then a zero-cycle hit in the same block
        req("cold_miss", 32'h40, 32'hAAAA0000, 1'b1, 3);
        req("warm_hit", 32'h44, 32'hAAAA0004, 1'b0, 0);

        // Conflict eviction at index 8
        req("conflict_c0", 32'hC0, 32'hAAAA0080, 1'b1, 3);
        req("evicted_40", 32'h40, 32'hAAAA0000, 1'b1, 3);

        // Three wait cycles before each word
        waitn = 3;
        req("wait_states", 32'h200, 32'hAAAA01C0, 1'b1, 9);
        waitn = 0;

        // inval arrives with the final word of a fill
        issue(32'h300, t0);
        expect_fill(32'h300);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        inval   = 1'b1;
        imemREN = 1'b0;
        @(posedge CLK); #1;
        inval = 1'b0;
        @(negedge CLK);
        check("inval_fetch_idle", {31'b0, iREN}, 32'h0);
        req("inval_probe_200", 32'h200, 32'hAAAA01C0, 1'b1, 3);

        // Address moves to 0x100 while 0x40 fills; the 0x40 probe also covers the inval
        issue(32'h40, t0);
        expect_fill(32'h40);
        expect_fill(32'h100);
        expect_hit(32'hAAAA00C0, t0 + 6);
        @(posedge CLK); #1;
        imemaddr = 32'h100;
        wait_hit("addr_change");
        req("both_hit_40", 32'h40, 32'hAAAA0000, 1'b0, 0);
        req("both_hit_104", 32'h104, 32'hAAAA00C4, 1'b0, 0);

        // inval in IDLE masks a would-be hit and clears the frame
        @(posedge CLK); #1;
        imemaddr = 32'h40;
        imemREN  = 1'b1;
        inval    = 1'b1;
        @(negedge CLK);
        check("inval_idle_ihit", {31'b0, ihit}, 32'h0);
        @(posedge CLK); #1;
        inval   = 1'b0;
        imemREN = 1'b0;
        req("inval_idle_miss", 32'h40, 32'hAAAA0000, 1'b1, 3);

        // Asynchronous reset in the middle of a waiting fill
        waitn = 3;
        issue(32'h80, t0);
        @(posedge CLK); #3;
        check("pre_rst_iREN", {31'b0, iREN}, 32'h1);
        RST = 1'b1;
        #1;
        check("async_rst_iREN", {31'b0, iREN}, 32'h0);
        check("async_rst_iaddr", iaddr, 32'h0);
        imemREN = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST   = 1'b0;
        waitn = 0;
        req("post_rst_miss", 32'h40, 32'hAAAA0000, 1'b1, 3);

        @(posedge CLK); #1;
        imemREN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("addr_q_drained", addr_q.size(), 32'h0);
        check("hit_q_drained", hit_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache between the datapath instruction port and the memory controller instruction channel. It replaces the single-cycle pass-through, which forwarded every fetch to memory.
- Hits return data combinationally in the request cycle.
- Misses run a multi-word block fill from memory and then retry.

## Interface
Parameters:
- SETS, 16: number of frames; power of two, ≥2.
- BLKWORDS, 2: 32-bit words per block; power of two, ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- inval  in  1  synchronous invalidate-all.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  instruction word for imemaddr; valid only when ihit=1.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, word-aligned.
- iwait  in  1  memory busy; the word on iload is accepted in a cycle with iREN=1 and iwait=0.
- iload  in  32  memory read data.

## Operation
Address split, with OFFW = log2(BLKWORDS) and IDXW = log2(SETS):
- [1:0] ignored.
- [OFFW+1:2] word offset.
- [IDXW+OFFW+1:OFFW+2] index.
- Remaining upper bits form the tag.

Each frame holds a valid bit, a tag and BLKWORDS data words.

FSM, icache_state_t:
- IDLE:
  - ihit = imemREN & valid[idx] & (tag[idx]==addr tag).
  - imemload = data[idx][offset].
  - iREN=0.
  - If imemREN and no hit: latch the block base address into fill_base, clear word counter cnt, go to FETCH.
- FETCH:
  - iREN=1, iaddr = fill_base + {cnt,2'b00}, ihit=0.
  - On each cycle with iwait=0: write iload into data[fill idx][cnt] and increment cnt.
  - On acceptance of word BLKWORDS-1: write the tag, set valid, return to IDLE.
- cnt width is max(1,OFFW) and never wraps mid-fill.

Boundary rules:
- imemREN dropped or imemaddr changed during FETCH: the fill runs to completion for the latched block. IDLE then re-evaluates the current address, so a changed address may trigger a second miss.
- inval in IDLE: all valid bits clear at the next edge, and ihit is forced 0 in the inval cycle.
- inval in FETCH: has priority over the fill. Valid bits clear, the fill is abandoned with no tag/valid write, cnt clears, state goes to IDLE.
- inval asserted together with the final fill word: inval wins, and that frame stays invalid.
- A fill replaces the frame regardless of its prior contents; no write-back is needed.

Reset (RST high, asynchronous):
- State IDLE, cnt=0, fill_base=0.
- All valid bits 0; tags and data 0.
- Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- RST mid-fill abandons the fill immediately. iREN drops without waiting for a clock edge.

## Timing
- Hit latency: 0 cycles; ihit and imemload are combinational from imemaddr in the same cycle.
- Miss latency:
  - Cycle 0: the miss is detected.
  - Cycle 1 onward: FETCH drives iREN.
  - Each word takes (wait cycles + 1).
  - ihit rises in the first IDLE cycle after the final accepted word.
  - Zero-wait BLKWORDS=2 miss: ihit rises in cycle 3.
- iREN and iaddr are decoded from registered state, cnt and fill_base only; they have no combinational path from imemaddr.
- iaddr changes only on a clock edge at which a word is accepted.

## Structure
- Shared package cache_pkg holds:
  - word_t (32-bit logic).
  - icache_state_t enum {IDLE, FETCH}.
  - Address-field widths derived from parameters, as localparams inside the module.
- Storage is inline flop arrays; no sub-module is required.
- Elaboration-time assertions check that SETS and BLKWORDS are powers of two.

## Test plan
All scenarios use SETS=16, BLKWORDS=2, so index = addr[6:3] and tag = addr[31:7].
- Cold miss: imemaddr=0x40, memory returns 0xAAAA0000 and 0xAAAA0004 with iwait=0.
  - Required: iaddr sequence 0x40 then 0x44.
  - Required: ihit=1 in cycle 3 with imemload=0xAAAA0000.
  - Required: a following fetch of 0x44 hits in 0 cycles with imemload 0xAAAA0004.
- Conflict eviction: after the cold-miss fill, fetch 0xC0 (same index 8, tag 1).
  - Required: miss and refill from 0xC0/0xC4.
  - Required: a subsequent fetch of 0x40 misses again.
- Wait states: iwait=1 for 3 cycles before each word.
  - Required: iaddr is held through each wait period.
  - Required: ihit rises on cycle 9.
- Address change mid-fill: switch imemaddr to 0x100 during the FETCH of 0x40.
  - Required: the fill of 0x40 completes, then a 0x100 miss follows.
  - Required: after both fills, both blocks hit.
- inval in FETCH on the last word: the cycle after, state is IDLE and every prior-valid address misses.
- Async RST during FETCH: iREN=0 immediately, before the next CLK edge; after release, fetch 0x40 misses.
